// File: rtl/sevseg_scan_driver.sv
// sevseg_scan_driver: multiplexed hex seven-segment scanner with tear-free, frame-boundary data loads.
// Define SEVSEG_LZB_EN to enable leading-zero blanking of digits above digit 0.
module sevseg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int DW = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT = DIGITS'(1);

  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     act_data_q, act_data_d, pend_data_q, pend_data_d, higher;
  logic [DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d, dp_sh, an_q, an_d;
  logic              pend_q, pend_d, dp_q, dp_d, fd_q, fd_d, wrap, bound, lz;
  logic [6:0]        seg_q, seg_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    wrap        = pre_q == PRE_LAST;
    bound       = wrap && idx_q == IDX_LAST;
    pre_d       = wrap ? '0 : pre_q + 1'b1;
    idx_d       = bound ? '0 : wrap ? idx_q + 1'b1 : idx_q;
    // A load on the boundary cycle goes straight to active and supersedes any pending value
    act_data_d  = !bound ? act_data_q : load ? data : pend_q ? pend_data_q : act_data_q;
    act_dp_d    = !bound ? act_dp_q : load ? dp_in : pend_q ? pend_dp_q : act_dp_q;
    pend_data_d = load ? data : pend_data_q;
    pend_dp_d   = load ? dp_in : pend_dp_q;
    pend_d      = !bound && (load || pend_q);
    higher      = act_data_q >> (4 * idx_q);
    dp_sh       = act_dp_q >> idx_q;
`ifdef SEVSEG_LZB_EN
    lz          = idx_q != '0 && higher == '0;
`else
    lz          = 1'b0;
`endif
    seg_d       = blank || lz ? '0 : decode(higher[3:0]);
    dp_d        = !blank && dp_sh[0];
    an_d        = blank ? '0 : ONE_HOT << idx_q;
    fd_d        = bound;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      idx_q       <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_q      <= 1'b0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      an_q        <= '0;
      fd_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_sevseg_scan_driver.sv
// tb_sevseg_scan_driver: table-driven decode checks, directed scan/tear/boundary/blank/reset sequences,
// and a random run compared every cycle against a cycle-count based reference model.
module tb_sevseg_scan_driver;
  localparam int D = 4;
  localparam int P = 4;

  logic clk = 0, rst_n = 0, load = 0, blank = 0;
  logic [15:0] data = 0;
  logic [3:0]  dp_in = 0;
  logic [6:0]  seg;
  logic        dp, frame_done;
  logic [3:0]  an;

  int n_tests = 0, n_fail = 0;
  logic chk_en = 0;

  sevseg_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in), .blank(blank),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_t [16];
  initial seg_t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: scan position derives from cycles since reset; outputs are one cycle late.
  int          cyc = 0;
  logic [15:0] m_act = 0, m_pdata = 0;
  logic [3:0]  m_dp = 0, m_pdp = 0;
  logic        m_pf = 0;
  logic [12:0] e_out = 0;

  function automatic logic is_bound(int c);
    return (c % (P * D)) == P * D - 1;
  endfunction

  function automatic logic [12:0] model_out(int c, logic [15:0] a, logic [3:0] d, logic b);
    int i = (c / P) % D;
    logic [15:0] hi = a >> (4 * i);
    logic [6:0] s = seg_t[hi[3:0]];
    logic [3:0] oh = 4'(1 << i);
`ifdef SEVSEG_LZB_EN
    if (i > 0 && hi == 0) s = 0;
`endif
    return b ? {12'b0, is_bound(c)} : {s, d[i], oh, is_bound(c)};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc <= 0; m_act <= 0; m_dp <= 0; m_pdata <= 0; m_pdp <= 0; m_pf <= 0; e_out <= 0;
    end else begin
      e_out <= model_out(cyc, m_act, m_dp, blank);
      if (is_bound(cyc)) begin
        if (load) begin m_act <= data; m_dp <= dp_in; end
        else if (m_pf) begin m_act <= m_pdata; m_dp <= m_pdp; end
        m_pf <= 0;
      end else if (load) begin
        m_pdata <= data; m_pdp <= dp_in; m_pf <= 1;
      end
      cyc <= cyc + 1;
    end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) chk("model", {19'b0, seg, dp, an, frame_done}, {19'b0, e_out});

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 40; i++) begin
      if (frame_done) return;
      @(negedge clk);
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_fd: frame_done timeout");
  endtask

  typedef struct {
    logic [15:0]      data;
    logic [3:0]       dpv;
    logic [3:0][6:0]  segs;
  } vec_t;
  vec_t vecs[5];

  task automatic show_vec(input vec_t v);
    data = v.data; dp_in = v.dpv; load = 1;
    step(1);
    load = 0;
    wait_fd();
    for (int k = 0; k < 4; k++) begin
      step(k == 0 ? 1 : 4);
      chk("vec_seg", 32'(seg), 32'(v.segs[k]));
      chk("vec_dp", 32'(dp), 32'(v.dpv[k]));
      chk("vec_an", 32'(an), 32'(1 << k));
    end
  endtask

  task automatic pulse_load(input logic [15:0] d);
    data = d; dp_in = 0; load = 1;
    step(1);
    load = 0;
  endtask

  initial begin
    vecs[0] = '{data: 16'hA5F0, dpv: 4'b0001, segs: {7'b1110111, 7'b1011011, 7'b1000111, 7'b1111110}};
    vecs[1] = '{data: 16'h1234, dpv: 4'b0000, segs: {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
    vecs[2] = '{data: 16'h6789, dpv: 4'b0101, segs: {7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011}};
    vecs[3] = '{data: 16'hBCDE, dpv: 4'b1010, segs: {7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111}};
`ifdef SEVSEG_LZB_EN
    vecs[4] = '{data: 16'h0030, dpv: 4'b0000, segs: {7'b0000000, 7'b0000000, 7'b1111001, 7'b1111110}};
`else
    vecs[4] = '{data: 16'h0030, dpv: 4'b0000, segs: {7'b1111110, 7'b1111110, 7'b1111001, 7'b1111110}};
`endif
    step(2);
    chk("reset_outputs", {19'b0, seg, dp, an, frame_done}, 32'h0);
    rst_n = 1;
    chk_en = 1;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      chk("scan_an", 32'(an), 32'(1 << ((i - 1) / 4)));
      chk("scan_fd", 32'(frame_done), 32'(i == 16));
      if (i <= 4) chk("scan_seg0", 32'(seg), 32'(7'b1111110));
    end
    for (int v = 0; v < 5; v++) show_vec(vecs[v]);

    // Tearing: load mid-frame while digit 1 is showing
    show_vec(vecs[3]);
    wait_fd();
    step(5);
    pulse_load(16'h1234);
    step(3);
    chk("tear_d2_old", 32'(seg), 32'(7'b1001110));
    step(4);
    chk("tear_d3_old", 32'(seg), 32'(7'b0011111));
    wait_fd();
    step(1);
    chk("tear_d0_new", 32'(seg), 32'(7'b0110011));
    step(4);
    chk("tear_d1_new", 32'(seg), 32'(7'b1111001));

    // Boundary load beats an older pending value
    wait_fd();
    step(2);
    pulse_load(16'h8888);
    step(12);
    data = 16'h5555; load = 1;
    step(1);
    load = 0;
    chk("bnd_fd", 32'(frame_done), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(k == 0 ? 1 : 4);
      chk("bnd_seg", 32'(seg), 32'(7'b1011011));
    end

    // Blank across a frame boundary
    wait_fd();
    step(13);
    blank = 1;
    for (int j = 14; j <= 19; j++) begin
      step(1);
      chk("blank_an", 32'(an), 32'h0);
      chk("blank_seg", 32'(seg), 32'h0);
      if (j == 16) chk("blank_fd", 32'(frame_done), 32'h1);
    end
    blank = 0;
    step(1);
    chk("blank_resume", 32'(an), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(1);
      load = ($urandom % 8) == 0;
      data = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom % 20 == 0) blank = ~blank;
    end
    blank = 0; load = 0;

    // Reset mid-frame discards a pending load
    step(3);
    pulse_load(16'h9999);
    #2 rst_n = 0;
    #1 chk("midreset_out", {19'b0, seg, dp, an, frame_done}, 32'h0);
    step(1);
    rst_n = 1;
    wait_fd();
    step(1);
    chk("midreset_d0", 32'(seg), 32'(7'b1111110));
    step(4);
`ifdef SEVSEG_LZB_EN
    chk("midreset_d1", 32'(seg), 32'h0);
`else
    chk("midreset_d1", 32'(seg), 32'(7'b1111110));
`endif
    step(2);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
